// File: rtl/bus_cmd_seq_pkg.sv
// Shared definitions for the bus command sequencer.
// The FSM state encoding and the bus constants are kept here so that the
// sequencer and any sub-blocks use one encoding.
package bus_cmd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    ISSUE    = 3'd2,
    WAIT_REL = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  localparam logic [1:0] CS_IDLE  = 2'b00;
  localparam logic       RW_READ  = 1'b1;
  localparam logic       RW_WRITE = 1'b0;

endpackage

// File: rtl/bus_cmd_seq_sync.sv
// Two-flop synchroniser for the asynchronous push-button.
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous active-low reset, clears both flops
//   din   - raw asynchronous input
//   dout  - synchronised level, two cycles behind din
module bus_cmd_seq_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/bus_cmd_seq.sv
// Bus command sequencer: turns a bouncy push-button plus slide switches into
// single-shot bus transactions. The button is synchronised, debounced on both
// press and release, and each accepted press snapshots the switches and drives
// CS for STROBE_LEN cycles. Exactly one transaction per press, no auto-repeat.
// Ports:
//   Clk, Reset                      - clock, async active-low reset
//   SW_Address/SW_RW/SW_CS/SW_AB    - switch settings, sampled on ISSUE entry
//   Btn                             - raw asynchronous push-button (active high)
//   Address/RW/CS/AB                - registered bus transaction outputs
//   Busy                            - high whenever the FSM is not IDLE
//   TxnCount                        - transactions issued since reset (wraps)
module bus_cmd_seq
  import bus_cmd_seq_pkg::*;
#(
  parameter int SIZE            = 5,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STROBE_LEN      = 1,
  parameter int CNTW            = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [SIZE-1:0] SW_Address,
  input  logic            SW_RW,
  input  logic [1:0]      SW_CS,
  input  logic            SW_AB,
  input  logic            Btn,
  output logic [SIZE-1:0] Address,
  output logic            RW,
  output logic [1:0]      CS,
  output logic            AB,
  output logic            Busy,
  output logic [CNTW-1:0] TxnCount
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int STW = $clog2(STROBE_LEN) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0] DB_MAX  = '1;
  localparam logic [STW-1:0] ST_LAST = STW'(STROBE_LEN - 1);

  logic           btn_s;
  state_t         state, state_n;
  logic [DBW-1:0] db_cnt, db_cnt_n;
  logic [STW-1:0] st_cnt, st_cnt_n;
  logic           capture, strobe_done;

  bus_cmd_seq_sync u_sync (
    .Clk  (Clk),
    .Reset(Reset),
    .din  (Btn),
    .dout (btn_s)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      db_cnt <= '0;
      st_cnt <= '0;
    end else begin
      state  <= state_n;
      db_cnt <= db_cnt_n;
      st_cnt <= st_cnt_n;
    end
  end

  // capture fires on the transition into ISSUE so the switch snapshot and CS
  // become visible in the first ISSUE cycle.
  always_comb begin
    state_n     = state;
    db_cnt_n    = db_cnt;
    st_cnt_n    = st_cnt;
    capture     = 1'b0;
    strobe_done = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          db_cnt_n = '0;
          state_n  = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_n  = ISSUE;
          capture  = 1'b1;
          st_cnt_n = '0;
        end else if (db_cnt != DB_MAX) begin
          db_cnt_n = db_cnt + 1'b1;
        end
      end
      ISSUE: begin
        if (st_cnt == ST_LAST) begin
          strobe_done = 1'b1;
          state_n     = WAIT_REL;
        end else begin
          st_cnt_n = st_cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!btn_s) begin
          db_cnt_n = '0;
          state_n  = REL_DB;
        end
      end
      REL_DB: begin
        if (btn_s) begin
          state_n = WAIT_REL;
        end else if (db_cnt == DB_LAST) begin
          state_n = IDLE;
        end else if (db_cnt != DB_MAX) begin
          db_cnt_n = db_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus outputs only change on capture and at the end of the strobe, so
  // switch movement outside ISSUE entry never reaches the bus.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Address  <= '0;
      RW       <= RW_READ;
      CS       <= CS_IDLE;
      AB       <= 1'b0;
      TxnCount <= '0;
    end else begin
      if (capture) begin
        Address <= SW_Address;
        RW      <= SW_RW;
        AB      <= SW_AB;
        CS      <= SW_CS;
      end
      if (strobe_done) begin
        CS       <= CS_IDLE;
        TxnCount <= TxnCount + 1'b1;
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_bus_cmd_seq.sv
// Self-checking bench for bus_cmd_seq (DEBOUNCE_CYCLES=4, STROBE_LEN=2).
// Each press pushes its expected transaction onto a scoreboard; a monitor
// pops and compares whenever TxnCount advances.
module tb_bus_cmd_seq;

  localparam int SIZE = 5;
  localparam int DB   = 4;
  localparam int SL   = 2;
  localparam int CNTW = 8;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic [SIZE-1:0] SW_Address = '0;
  logic            SW_RW = 1'b0;
  logic [1:0]      SW_CS = 2'b00;
  logic            SW_AB = 1'b0;
  logic            Btn = 1'b0;
  logic [SIZE-1:0] Address;
  logic            RW;
  logic [1:0]      CS;
  logic            AB;
  logic            Busy;
  logic [CNTW-1:0] TxnCount;

  bus_cmd_seq #(
    .SIZE(SIZE), .DEBOUNCE_CYCLES(DB), .STROBE_LEN(SL), .CNTW(CNTW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .SW_Address(SW_Address), .SW_RW(SW_RW),
    .SW_CS(SW_CS), .SW_AB(SW_AB), .Btn(Btn), .Address(Address), .RW(RW),
    .CS(CS), .AB(AB), .Busy(Busy), .TxnCount(TxnCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [SIZE-1:0] addr;
    logic            rw;
    logic            ab;
    logic [1:0]      cs;
    logic [CNTW-1:0] cnt;
  } txn_t;

  txn_t            sb[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [CNTW-1:0] exp_cnt = '0;

  // Monitor: accumulates the CS strobe and checks each completed transaction.
  logic [CNTW-1:0] prev_cnt = '0;
  int              cs_len = 0;
  logic [1:0]      cs_val = 2'b00;
  txn_t            mon_e;
  int              exp_len;

  initial begin
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        prev_cnt = '0;
        cs_len   = 0;
        cs_val   = 2'b00;
      end else begin
        if (CS != 2'b00) begin
          cs_val = CS;
          cs_len++;
        end
        if (TxnCount != prev_cnt) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_txn: TxnCount=%0d but no press was queued", TxnCount);
          end else begin
            mon_e   = sb.pop_front();
            exp_len = (mon_e.cs == 2'b00) ? 0 : SL;
            if (Address !== mon_e.addr || RW !== mon_e.rw || AB !== mon_e.ab ||
                TxnCount !== mon_e.cnt || cs_val !== mon_e.cs || cs_len != exp_len) begin
              n_fail++;
              $display("FAIL txn: got addr=%h rw=%b ab=%b cs=%b len=%0d cnt=%0d, want addr=%h rw=%b ab=%b cs=%b len=%0d cnt=%0d",
                       Address, RW, AB, cs_val, cs_len, TxnCount,
                       mon_e.addr, mon_e.rw, mon_e.ab, mon_e.cs, exp_len, mon_e.cnt);
            end
          end
          prev_cnt = TxnCount;
          cs_len   = 0;
          cs_val   = 2'b00;
        end
      end
    end
  end

  task automatic push_expected();
    txn_t e;
    exp_cnt = exp_cnt + 1'b1;
    e.addr  = SW_Address;
    e.rw    = SW_RW;
    e.ab    = SW_AB;
    e.cs    = SW_CS;
    e.cnt   = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic press(input int hold, input int rel);
    push_expected();
    Btn = 1'b1;
    repeat (hold) @(negedge Clk);
    Btn = 1'b0;
    repeat (rel) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Btn   = 1'b1;
    SW_Address = SIZE'($urandom);
    SW_RW = 1'($urandom);
    SW_CS = 2'($urandom);
    SW_AB = 1'($urandom);
    repeat (3) @(negedge Clk);
    n_tests++;
    if (Address !== 5'h00 || RW !== 1'b1 || CS !== 2'b00 || AB !== 1'b0 ||
        Busy !== 1'b0 || TxnCount !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h rw=%b cs=%b ab=%b busy=%b cnt=%0d, want 00 1 00 0 0 0",
               Address, RW, CS, AB, Busy, TxnCount);
    end
    Btn   = 1'b0;
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      n_tests++;
      if (Address !== 5'h00 || RW !== 1'b1 || CS !== 2'b00 || AB !== 1'b0 ||
          Busy !== 1'b0 || TxnCount !== 8'd0) begin
        n_fail++;
        $display("FAIL post_reset_idle cycle %0d: addr=%h rw=%b cs=%b ab=%b busy=%b cnt=%0d, want reset values",
                 i, Address, RW, CS, AB, Busy, TxnCount);
      end
    end
  endtask

  task automatic test_clean_press();
    int lat;
    SW_Address = 5'h13;
    SW_RW = 1'b0;
    SW_CS = 2'b10;
    SW_AB = 1'b1;
    push_expected();
    Btn = 1'b1;
    lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge Clk);
      if (CS != 2'b00) begin
        lat = k;
        break;
      end
    end
    n_tests++;
    if (lat != 2 + DB + 1) begin
      n_fail++;
      $display("FAIL press_latency: CS rose after %0d cycles (0 = never), want %0d", lat, 2 + DB + 1);
    end
    repeat (30 - lat) @(negedge Clk);
    n_tests++;
    if (Busy !== 1'b1 || CS !== 2'b00 || TxnCount !== exp_cnt) begin
      n_fail++;
      $display("FAIL held_single_txn: busy=%b cs=%b cnt=%0d, want 1 00 %0d", Busy, CS, TxnCount, exp_cnt);
    end
    Btn = 1'b0;
    repeat (12) @(negedge Clk);
    n_tests++;
    if (Busy !== 1'b0 || TxnCount !== exp_cnt || sb.size() != 0) begin
      n_fail++;
      $display("FAIL clean_release: busy=%b cnt=%0d pending=%0d, want 0 %0d 0", Busy, TxnCount, sb.size(), exp_cnt);
    end
  endtask

  task automatic test_bounce();
    bit saw_cs;
    saw_cs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Btn = (i % 2 == 0);
      @(negedge Clk);
      if (CS != 2'b00) saw_cs = 1'b1;
    end
    Btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (CS != 2'b00) saw_cs = 1'b1;
    end
    n_tests++;
    if (saw_cs || Busy !== 1'b0 || TxnCount !== exp_cnt) begin
      n_fail++;
      $display("FAIL bounce_reject: saw_cs=%b busy=%b cnt=%0d, want 0 0 %0d", saw_cs, Busy, TxnCount, exp_cnt);
    end
  endtask

  task automatic test_switch_change();
    push_expected();
    Btn = 1'b1;
    repeat (12) @(negedge Clk);
    SW_Address = 5'h02;
    SW_RW = 1'b1;
    SW_AB = 1'b0;
    repeat (5) @(negedge Clk);
    n_tests++;
    if (Address !== 5'h13 || RW !== 1'b0 || AB !== 1'b1 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL switch_hold: addr=%h rw=%b ab=%b busy=%b, want 13 0 1 1", Address, RW, AB, Busy);
    end
    Btn = 1'b0;
    repeat (12) @(negedge Clk);
    n_tests++;
    if (Address !== 5'h13 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL switch_after_release: addr=%h busy=%b, want 13 0", Address, Busy);
    end
    press(12, 12);
    n_tests++;
    if (Address !== 5'h02 || RW !== 1'b1 || AB !== 1'b0 || TxnCount !== exp_cnt || sb.size() != 0) begin
      n_fail++;
      $display("FAIL second_press: addr=%h rw=%b ab=%b cnt=%0d pending=%0d, want 02 1 0 %0d 0",
               Address, RW, AB, TxnCount, sb.size(), exp_cnt);
    end
  endtask

  task automatic test_release_bounce();
    push_expected();
    Btn = 1'b1;
    repeat (12) @(negedge Clk);
    Btn = 1'b0;
    repeat (2) @(negedge Clk);
    Btn = 1'b1;
    repeat (20) @(negedge Clk);
    n_tests++;
    if (TxnCount !== exp_cnt || Busy !== 1'b1 || CS !== 2'b00 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL release_bounce: cnt=%0d busy=%b cs=%b pending=%0d, want %0d 1 00 0",
               TxnCount, Busy, CS, sb.size(), exp_cnt);
    end
    Btn = 1'b0;
    repeat (12) @(negedge Clk);
    n_tests++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_release: busy=%b, want 0", Busy);
    end
    // Deselected capture: the transaction still counts but CS never rises.
    SW_Address = 5'h1f;
    SW_RW = 1'b1;
    SW_CS = 2'b00;
    SW_AB = 1'b0;
    press(12, 12);
    n_tests++;
    if (TxnCount !== exp_cnt || Address !== 5'h1f || sb.size() != 0) begin
      n_fail++;
      $display("FAIL cs_zero_txn: cnt=%0d addr=%h pending=%0d, want %0d 1f 0", TxnCount, Address, sb.size(), exp_cnt);
    end
  endtask

  task automatic test_wrap_abort();
    bit seen;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    sb.delete();
    exp_cnt = '0;
    @(negedge Clk);
    for (int i = 0; i < 256; i++) begin
      SW_Address = SIZE'($urandom);
      SW_RW = 1'($urandom);
      SW_CS = 2'($urandom);
      SW_AB = 1'($urandom);
      press(10, 10);
      if (i == 254) begin
        n_tests++;
        if (TxnCount !== 8'd255) begin
          n_fail++;
          $display("FAIL count_255: cnt=%0d, want 255", TxnCount);
        end
      end
    end
    n_tests++;
    if (TxnCount !== 8'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL count_wrap: cnt=%0d pending=%0d, want 0 0", TxnCount, sb.size());
    end
    // One more press to get a nonzero count, then abort the next strobe.
    SW_CS = 2'b11;
    press(10, 10);
    SW_CS = 2'b01;
    Btn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      if (CS != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_strobe_start: CS never rose within 50 cycles, want 01");
    end
    #2 Reset = 1'b0;
    #1;
    n_tests++;
    if (CS !== 2'b00 || TxnCount !== 8'd0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: cs=%b cnt=%0d busy=%b, want 00 0 0", CS, TxnCount, Busy);
    end
    Btn = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    exp_cnt = '0;
    repeat (12) @(negedge Clk);
    n_tests++;
    if (CS !== 2'b00 || TxnCount !== 8'd0 || Busy !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL abort_after: cs=%b cnt=%0d busy=%b pending=%0d, want 00 0 0 0", CS, TxnCount, Busy, sb.size());
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_switch_change();
    test_release_bounce();
    test_wrap_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, tests run=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
